mux_chan_seq: RTL
=================

// Module: mux_chan_seq
// PURPOSE
//  Parametrised, registered N-channel, W-bit multiplexer with manual and auto-scan
//  select modes and a valid/ready output handshake. Next generation of the 4:1 bit mux.
//  Sits between multi-channel sample sources and a single downstream consumer;
//  supports time-division polling of all channels without external select logic.
// PARAMETERS
//  N      4  number of input channels, N >= 2
//  W      1  data width per channel, W >= 1
//  DWELL  1  accepted captures per channel in scan mode before advancing, DWELL >= 1
//  SW     $clog2(N)  select/index width (localparam, derived)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  din        in   N*W   flattened channel data; channel k = din[k*W +: W]
//  sel        in   SW    manual channel select
//  mode       in   1     0 = MANUAL, 1 = SCAN
//  en         in   1     capture request
//  out_ready  in   1     consumer accepts dout this cycle
//  dout       out  W     registered selected data
//  dout_ch    out  SW    channel index dout was captured from
//  dout_valid out  1     dout/dout_ch hold a sample not yet accepted
//  sel_err    out  1     one-cycle pulse: manual sel >= N at a capture slot
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-scan): dout=0, dout_ch=0, dout_valid=0, sel_err=0,
//    state=MANUAL, scan index=0, dwell count=0. Release is synchronous to clk.
//  - Capture slot: en=1 && (!dout_valid || out_ready). Latency 1 cycle din -> dout.
//  - At capture slot: dout<=din[ch], dout_ch<=ch, dout_valid<=1 (ch per state).
//  - No capture slot and out_ready=1: dout_valid<=0; dout/dout_ch hold last value.
//  - dout_valid=1 && out_ready=0: dout, dout_ch, dout_valid, scan index all frozen.
//  - Simultaneous accept + capture: back-to-back, one sample per cycle, no bubble.
//  - FSM, mode sampled every cycle:
//    MANUAL: ch=sel. If sel >= N at capture slot: no capture, dout_valid<=0 if out_ready,
//            sel_err<=1 for one cycle. MANUAL->SCAN when mode=1: index=0, dwell=0.
//    SCAN:   ch=index. Each capture increments dwell; at dwell=DWELL-1 dwell<=0 and
//            index<=index+1, wrapping N-1 -> 0 (non-power-of-2 N wraps at N-1). sel ignored.
//            SCAN->MANUAL when mode=0; index/dwell retained but restart on next SCAN entry.
//  - Mode change takes effect in the cycle it is seen; the capture that cycle uses new state.
//  - sel_err is 0 in SCAN; it never asserts on a cycle without a capture slot.
// CONFIGURATION
//  MUX_CHAN_PARITY_EN defined: extra port dout_par out 1 = ^din[ch], registered with dout,
//    reset 0, held/frozen exactly as dout.
//  Not defined: port absent, no parity logic.
// STRUCTURE
//  Shared package mux_pkg: MODE_MANUAL=1'b0 / MODE_SCAN=1'b1 encodings, FSM state
//    localparams ST_MANUAL/ST_SCAN, clog2 helper function.
//  Sub-module mux_scan_ctr: scan index + dwell counter with clear, advance, freeze
//    inputs, params N, DWELL; top holds FSM, select decode, output register.
// TESTING
//  1 Reset: assert rst mid-stream with dout_valid=1 -> all outputs 0 same cycle, index 0.
//  2 Manual, N=4 W=8, din={8'hD3,8'hC2,8'hB1,8'hA0}, sel=2, en=1, out_ready=1 ->
//    next cycle dout=8'hC2, dout_ch=2, dout_valid=1.
//  3 Backpressure: valid=1, out_ready=0 for 3 cycles while sel/din change -> dout, dout_ch
//    stable; out_ready=1 -> new sample next cycle, no gap.
//  4 Scan, N=3 DWELL=2, en=1, out_ready=1 -> dout_ch sequence 0,0,1,1,2,2,0,0.
//  5 Manual N=3, sel=3 with en=1 -> sel_err one-cycle pulse, dout_valid=0, dout held.
//  6 MUX_CHAN_PARITY_EN, din ch1=8'h07 -> dout_par=1; ch0=8'h03 -> dout_par=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared encodings and helpers for the channel-mux family.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_chan_seq_if.sv
// Channel-mux bus: sample inputs, select controls and the registered output handshake.
// MUX_CHAN_PARITY_EN adds the dout_par signal.
interface mux_chan_seq_if #(
  parameter int N = 4,
  parameter int W = 1
);
  import mux_pkg::*;

  localparam int SW = clog2(N);

  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           en;
  logic           out_ready;
  logic [W-1:0]   dout;
  logic [SW-1:0]  dout_ch;
  logic           dout_valid;
  logic           sel_err;
`ifdef MUX_CHAN_PARITY_EN
  logic           dout_par;
`endif

  modport master (
    output din, sel, mode, en, out_ready,
`ifdef MUX_CHAN_PARITY_EN
    input  dout_par,
`endif
    input  dout, dout_ch, dout_valid, sel_err
  );

  modport slave (
    input  din, sel, mode, en, out_ready,
`ifdef MUX_CHAN_PARITY_EN
    output dout_par,
`endif
    output dout, dout_ch, dout_valid, sel_err
  );

endinterface

// File: rtl/mux_scan_ctr.sv
// Scan position (channel index + dwell count); idx is the position in effect this cycle.
// No latency on clear (idx reads 0 the same cycle); freeze blocks advance while output is stalled.
module mux_scan_ctr import mux_pkg::*; #(
  parameter int N     = 4,
  parameter int DWELL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 advance,
  input  logic                 freeze,
  output logic [clog2(N)-1:0]  idx
);
  localparam int SW  = clog2(N);
  localparam int DCW = (DWELL > 1) ? clog2(DWELL) : 1;

  logic [SW-1:0]  idx_q, base_idx, idx_d;
  logic [DCW-1:0] dw_q, base_dw, dw_d;

  // A clear and an advance in the same cycle step from the restarted position.
  always_comb begin
    base_idx = clear ? '0 : idx_q;
    base_dw  = clear ? '0 : dw_q;
    idx_d    = base_idx;
    dw_d     = base_dw;
    if (advance && !freeze) begin
      if (base_dw == DCW'(DWELL - 1)) begin
        dw_d  = '0;
        idx_d = (base_idx == SW'(N - 1)) ? '0 : base_idx + SW'(1);
      end else begin
        dw_d  = base_dw + DCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      dw_q  <= '0;
    end else begin
      idx_q <= idx_d;
      dw_q  <= dw_d;
    end
  end

  assign idx = base_idx;

endmodule

// File: rtl/mux_chan_seq.sv
// Registered N:1 channel mux with manual select and auto-scan; MUX_CHAN_PARITY_EN adds dout_par.
// Latency 1 cycle din->dout; dout_valid && !out_ready freezes the output and the scan position.
module mux_chan_seq import mux_pkg::*; #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 1
) (
  input  logic          clk,
  input  logic          rst,
  mux_chan_seq_if.slave bus
);
  localparam int SW = clog2(N);

  state_e        state, state_nxt;
  logic          scan_act, scan_clear, stall, slot, ch_ok, cap, err_nxt;
  logic [SW-1:0] scan_idx, ch;
  logic [W-1:0]  ch_dat;
  logic [W-1:0]  dout_q;
  logic [SW-1:0] dout_ch_q;
  logic          valid_q, err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_MANUAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = (bus.mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
  end

  // Mode acts in the cycle it is seen, so decode from the next state.
  always_comb begin
    scan_act   = (state_nxt == ST_SCAN);
    scan_clear = scan_act && (state == ST_MANUAL);
    stall      = valid_q && !bus.out_ready;
    slot       = bus.en && !stall;
    ch         = scan_act ? scan_idx : bus.sel;
    ch_ok      = scan_act || ({1'b0, bus.sel} < (SW + 1)'(N));
    cap        = slot && ch_ok;
    err_nxt    = slot && !ch_ok;
  end

  always_comb begin
    ch_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (ch == SW'(k)) ch_dat = bus.din[k*W +: W];
    end
  end

  mux_scan_ctr #(.N(N), .DWELL(DWELL)) u_scan_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (scan_clear),
    .advance (cap && scan_act),
    .freeze  (stall),
    .idx     (scan_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q    <= '0;
      dout_ch_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_nxt;
      if (cap) begin
        dout_q    <= ch_dat;
        dout_ch_q <= ch;
        valid_q   <= 1'b1;
      end else if (bus.out_ready) begin
        valid_q   <= 1'b0;
      end
    end
  end

`ifdef MUX_CHAN_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      par_q <= 1'b0;
    else if (cap) par_q <= ^ch_dat;
  end
  assign bus.dout_par = par_q;
`endif

  assign bus.dout       = dout_q;
  assign bus.dout_ch    = dout_ch_q;
  assign bus.dout_valid = valid_q;
  assign bus.sel_err    = err_q;

endmodule
